// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables and GF(2^8) helpers used by the AES-256 decryptor.
package aes_pkg;

    localparam int unsigned NR      = 14;
    localparam int unsigned NK      = 8;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KEY_W   = 256;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] n);
        case (n)
            3'd1:    return 8'h01;
            3'd2:    return 8'h02;
            3'd3:    return 8'h04;
            3'd4:    return 8'h08;
            3'd5:    return 8'h10;
            3'd6:    return 8'h20;
            3'd7:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_expand_256.sv
// AES-256 key schedule, one 32-bit word per enabled cycle; word 0 is emitted on the start edge.
module aes_key_expand_256
    import aes_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [31:0]      word_o,
    output logic [5:0]       word_idx_o,
    output logic             word_valid_o,
    output logic             done_o
);

    logic             run_q;
    logic [5:0]       idx_q;
    logic [KEY_W-1:0] win_q;   // last eight words, oldest in the low slot
    logic             start_eff;
    logic [31:0]      last_w;
    logic [31:0]      tmp_w;
    logic [31:0]      next_w;

    assign start_eff = start_i & ~run_q;

    always_comb begin
        last_w = win_q[KEY_W-1 -: 32];
        tmp_w  = last_w;
        if (idx_q[2:0] == 3'd0) begin
            tmp_w = sub_word({last_w[7:0], last_w[31:8]}) ^ {24'h0, rcon(idx_q[5:3])};
        end else if (idx_q[2:0] == 3'd4) begin
            tmp_w = sub_word(last_w);
        end
        next_w = win_q[31:0] ^ tmp_w;
    end

    always_comb begin
        word_valid_o = enable_i & (start_eff | run_q);
        word_idx_o   = start_eff ? 6'd0 : idx_q;
        if (start_eff) begin
            word_o = key_i[31:0];
        end else if (idx_q < 6'(NK)) begin
            word_o = win_q[{idx_q[2:0], 5'd0} +: 32];
        end else begin
            word_o = next_w;
        end
        done_o = enable_i & run_q & (idx_q == 6'd59);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            idx_q <= 6'd0;
            win_q <= '0;
        end else if (enable_i) begin
            if (start_eff) begin
                win_q <= key_i;
                idx_q <= 6'd1;
                run_q <= 1'b1;
            end else if (run_q) begin
                if (idx_q >= 6'(NK)) win_q <= {next_w, win_q[KEY_W-1:32]};
                if (idx_q == 6'd59) run_q <= 1'b0;
                else                idx_q <= idx_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/decrypt_aes256_ecb.sv
// Iterative AES-256 ECB decryptor, one round per cycle.
// Optional 8-deep input FIFO enabled by defining AES_DEC_IN_FIFO_EN.
module decrypt_aes256_ecb
    import aes_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic               key_load_i,
    input  logic               process_start_i,
    input  logic [BLOCK_W-1:0] bytes_i,
    output logic               busy_o,
    output logic [BLOCK_W-1:0] bytes_o,
    output logic               bytes_valid_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYEXP = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] FINAL  = 3'd4;

    logic [2:0]         fsm_q, fsm_d, fsm_cur;
    logic [3:0]         rnd_q, rnd_d, rk_idx;
    logic [BLOCK_W-1:0] state_q, state_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic               valid_q, valid_d;
    logic               key_valid_q, key_valid_d;
    logic [31:0]        rk_mem [0:59];
    logic [BLOCK_W-1:0] rk_cur, t_round, blk;
    logic               accept, kx_start, kx_valid, kx_done;
    logic [31:0]        kx_word;
    logic [5:0]         kx_idx;

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d)
                            ^ gf_mul(a3, 8'h09);
            o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b)
                            ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e)
                            ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09)
                            ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_DEC_IN_FIFO_EN
    logic [BLOCK_W-1:0] fifo_mem [0:7];
    logic [2:0]         wr_ptr_q, rd_ptr_q;
    logic [3:0]         cnt_q;
    logic               push, pop;

    assign busy_o = (cnt_q == 4'd8) | ~key_valid_q;
    assign push   = enable_i & process_start_i & ~busy_o;
    assign pop    = enable_i & (fsm_q == IDLE) & ~key_load_i & key_valid_q & (cnt_q != 4'd0);
    assign accept = pop;
    assign blk    = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            cnt_q    <= 4'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
            cnt_q <= cnt_q + {3'd0, push} - {3'd0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= bytes_i;
    end
`else
    assign busy_o = (fsm_q != IDLE) | ~key_valid_q;
    // A start alongside a key load is dropped: the load wins the IDLE cycle.
    assign accept = enable_i & process_start_i & ~busy_o & ~key_load_i;
    assign blk    = bytes_i;
`endif

    assign kx_start = enable_i & (fsm_q == IDLE) & key_load_i;

    aes_key_expand_256 u_key_expand (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .start_i      (kx_start),
        .key_i        (key_i),
        .word_o       (kx_word),
        .word_idx_o   (kx_idx),
        .word_valid_o (kx_valid),
        .done_o       (kx_done)
    );

    always_ff @(posedge clk_i) begin
        if (kx_valid) rk_mem[kx_idx] <= kx_word;
    end

    // The acceptance edge is the INIT step; the FSM never rests there.
    assign fsm_cur = accept ? INIT : fsm_q;

    always_comb begin
        case (fsm_cur)
            INIT:    rk_idx = 4'(NR);
            FINAL:   rk_idx = 4'd0;
            default: rk_idx = rnd_q;
        endcase
        for (int j = 0; j < 4; j++) rk_cur[32*j +: 32] = rk_mem[{rk_idx, j[1:0]}];
        t_round = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_cur;
    end

    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_d     = state_q;
        out_d       = out_q;
        valid_d     = valid_q;
        key_valid_d = key_valid_q;
        if (enable_i) begin
            valid_d = 1'b0;
            case (fsm_cur)
                IDLE: begin
                    if (key_load_i) begin
                        fsm_d       = KEYEXP;
                        key_valid_d = 1'b0;
                    end
                end
                KEYEXP: begin
                    if (kx_done) begin
                        fsm_d       = IDLE;
                        key_valid_d = 1'b1;
                    end
                end
                INIT: begin
                    state_d = blk ^ rk_cur;
                    rnd_d   = 4'(NR - 1);
                    fsm_d   = ROUND;
                end
                ROUND: begin
                    state_d = inv_mix_columns(t_round);
                    if (rnd_q == 4'd1) fsm_d = FINAL;
                    else               rnd_d = rnd_q - 4'd1;
                end
                FINAL: begin
                    out_d   = t_round;
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            state_q     <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign bytes_o       = out_q;
    // A held strobe is masked while disabled and shows again once enable returns.
    assign bytes_valid_o = valid_q & enable_i;

endmodule
